// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, state encoding and baud defaults for TX and RX.
package uart_pkg;
  localparam int UART_DATA_BITS = 8;
  localparam int UART_WIDTH = 16;
  localparam int UART_DIV = 10417;
  localparam int UART_FRAME_BITS = UART_DATA_BITS + 2;
  localparam int UART_FRAME_BITS_PAR = UART_DATA_BITS + 3;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: counts 0..div-1 and flags the last (tick) and next-to-last (pre_tick) clock of each bit.
module uart_baud_gen import uart_pkg::*; #(
  parameter int width = UART_WIDTH,
  parameter logic [width-1:0] div = width'(UART_DIV)
) (
  input  logic clk,
  input  logic arst,
  input  logic clr,
  output logic tick,
  output logic pre_tick
);
  logic [width-1:0] cnt;
  assign tick = cnt == div - width'(1);
  assign pre_tick = cnt == div - width'(2);
  always_ff @(posedge clk or posedge arst)
    if (arst) cnt <= '0;
    else cnt <= (clr || tick) ? '0 : cnt + width'(1);
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 (optional parity) UART transmitter, LSB first, registered outputs.
module uart_tx import uart_pkg::*; #(
  parameter int width = UART_WIDTH,
  parameter logic [width-1:0] div = width'(UART_DIV),
  parameter bit PARITY_EN = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       arst,
  input  logic       tx_en,
  input  logic       tx_start,
  input  logic [7:0] data_in,
  output logic       tx,
  output logic       busy,
  output logic       done
);
  uart_state_t state;
  logic [UART_DATA_BITS-1:0] shreg;
  logic [2:0] idx;
  logic tick, pre_tick, parity;
  assign parity = ^shreg ^ PARITY_ODD;
  uart_baud_gen #(.width(width), .div(div)) u_baud (
    .clk(clk),
    .arst(arst),
    .clr(state == IDLE),
    .tick(tick),
    .pre_tick(pre_tick)
  );
  // The stop bit leaves one clock early so the done cycle is its last clock and a new start follows seamlessly.
  always_ff @(posedge clk or posedge arst)
    if (arst) begin
      state <= IDLE;
      tx <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
      idx <= '0;
      shreg <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (tx_en && tx_start) begin
          shreg <= data_in;
          idx <= '0;
          tx <= 1'b0;
          busy <= 1'b1;
          state <= START;
        end
        START: if (tick) begin
          tx <= shreg[0];
          state <= DATA;
        end
        DATA: if (tick) begin
          if (idx == '1) begin
            tx <= PARITY_EN ? parity : 1'b1;
            state <= PARITY_EN ? PARITY : STOP;
            idx <= '0;
          end else begin
            tx <= shreg[idx + 3'd1];
            idx <= idx + 3'd1;
          end
        end
        PARITY: if (tick) begin
          tx <= 1'b1;
          state <= STOP;
        end
        STOP: if (pre_tick) begin
          busy <= 1'b0;
          done <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx at div=16, plus even/odd parity variants.
module tb_uart_tx;
  import uart_pkg::*;
  localparam int D = 16;
  localparam int FL = UART_FRAME_BITS * D;
  logic clk, arst, tx_en, tx_start;
  logic [7:0] data_in;
  logic tx, busy, done;
  logic p_start;
  logic [7:0] p_data;
  logic p_tx, p_busy, p_done, o_tx, o_busy, o_done;
  int checks, errors;
  logic [7:0] q[$];
  logic [8:0] pq[$];
  logic line_s [1:400];
  logic busy_s [1:400];
  logic done_s [1:400];
  logic p_line [1:400];
  logic o_line [1:400];
  logic [10:0] bits;
  int unstable, done_at, done_cnt, busy_cnt, busy_last;

  uart_tx #(.width(16), .div(16'd16)) dut (
    .clk(clk), .arst(arst), .tx_en(tx_en), .tx_start(tx_start), .data_in(data_in),
    .tx(tx), .busy(busy), .done(done)
  );
  uart_tx #(.width(16), .div(16'd16), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_p (
    .clk(clk), .arst(arst), .tx_en(tx_en), .tx_start(p_start), .data_in(p_data),
    .tx(p_tx), .busy(p_busy), .done(p_done)
  );
  uart_tx #(.width(16), .div(16'd16), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut_o (
    .clk(clk), .arst(arst), .tx_en(tx_en), .tx_start(p_start), .data_in(p_data),
    .tx(o_tx), .busy(o_busy), .done(o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records n cycles after an acceptance edge (index k = cycle T+k) and measures the frame.
  task automatic capture(input int n, input int nb, input int en_off);
    unstable = 0; done_at = 0; done_cnt = 0; busy_cnt = 0; busy_last = 0; bits = '0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      line_s[k] = tx; busy_s[k] = busy; done_s[k] = done;
      tx_start = 1'b0;
      if (k == en_off) tx_en = 1'b0;
      if (done) begin done_cnt++; if (done_at == 0) done_at = k; end
      if (busy) begin busy_cnt++; busy_last = k; end
    end
    for (int b = 0; b < nb; b++) begin
      bits[b] = line_s[b * D + 8];
      for (int c = 1; c <= D; c++) if (line_s[b * D + c] !== bits[b]) unstable++;
    end
  endtask

  task automatic test_reset;
    arst = 1'b1; tx_en = 1'b1; tx_start = 1'b0; data_in = '0; p_start = 1'b0; p_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b exp 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (p_tx !== 1'b1) begin errors++; $display("FAIL reset_p_tx got %b exp 1", p_tx); end
    arst = 1'b0;
  endtask

  task automatic test_frame;
    logic [7:0] pats [3] = '{8'hA5, 8'h01, 8'h80};
    logic [7:0] e;
    logic [9:0] ef;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); data_in = pats[i]; tx_start = 1'b1; q.push_back(pats[i]);
      capture(FL + 10, UART_FRAME_BITS, 0);
      e = q.pop_front(); ef = {1'b1, e, 1'b0};
      checks++; if (bits[9:0] !== ef) begin errors++; $display("FAIL frame_bits got %b exp %b", bits[9:0], ef); end
      checks++; if (unstable != 0) begin errors++; $display("FAIL frame_bit_width got %0d unstable exp 0", unstable); end
      checks++; if (done_at != FL) begin errors++; $display("FAIL frame_done_at got %0d exp %0d", done_at, FL); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL frame_done_cnt got %0d exp 1", done_cnt); end
      checks++; if (busy_cnt != FL - 1 || busy_last != FL - 1)
        begin errors++; $display("FAIL frame_busy got cnt %0d last %0d exp %0d", busy_cnt, busy_last, FL - 1); end
    end
  endtask

  task automatic test_back_to_back;
    logic [9:0] f1, f2, e1, e2;
    int dn, d1, d2, zeros;
    dn = 0; d1 = 0; d2 = 0; zeros = 0;
    @(negedge clk); data_in = 8'h55; tx_start = 1'b1; q.push_back(8'h55);
    for (int k = 1; k <= 360; k++) begin
      @(negedge clk);
      line_s[k] = tx;
      if (done) begin dn++; if (d1 == 0) d1 = k; else d2 = k; end
      if (k > 2 * FL && tx === 1'b0) zeros++;
      if (k == 1) begin data_in = 8'hAA; q.push_back(8'hAA); end
      if (k == 170) data_in = 8'h00;
      if (k == 200 || k == 251 || k == 301) tx_start = 1'b0;
      if (k == 250 || k == 300) tx_start = 1'b1;
    end
    for (int b = 0; b < UART_FRAME_BITS; b++) begin
      f1[b] = line_s[b * D + 8];
      f2[b] = line_s[FL + b * D + 8];
    end
    e1 = {1'b1, q.pop_front(), 1'b0};
    e2 = {1'b1, q.pop_front(), 1'b0};
    checks++; if (f1 !== e1) begin errors++; $display("FAIL b2b_frame1 got %b exp %b", f1, e1); end
    checks++; if (f2 !== e2) begin errors++; $display("FAIL b2b_frame2 got %b exp %b", f2, e2); end
    checks++; if (dn != 2) begin errors++; $display("FAIL b2b_done_cnt got %0d exp 2", dn); end
    checks++; if (d1 != FL || d2 != 2 * FL) begin errors++; $display("FAIL b2b_done_at got %0d,%0d exp %0d,%0d", d1, d2, FL, 2 * FL); end
    checks++; if (line_s[FL] !== 1'b1 || line_s[FL + 1] !== 1'b0)
      begin errors++; $display("FAIL b2b_gap got stop_end %b next %b exp 1 0", line_s[FL], line_s[FL + 1]); end
    checks++; if (zeros != 0) begin errors++; $display("FAIL b2b_third_frame got %0d low cycles exp 0", zeros); end
  endtask

  task automatic test_reset_mid;
    logic [9:0] ef;
    int dn, hi;
    dn = 0; hi = 0;
    @(negedge clk); data_in = 8'hC3; tx_start = 1'b1;
    for (int k = 1; k <= 60; k++) begin @(negedge clk); tx_start = 1'b0; end
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL rst_mid_inflight got %b exp 0", tx); end
    arst = 1'b1; #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rst_mid_tx got %b exp 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", busy); end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) dn++;
      if (tx !== 1'b1) hi++;
    end
    checks++; if (dn != 0 || hi != 0) begin errors++; $display("FAIL rst_mid_hold got done %0d low %0d exp 0 0", dn, hi); end
    arst = 1'b0; data_in = 8'h96; tx_start = 1'b1; q.push_back(8'h96);
    capture(FL + 10, UART_FRAME_BITS, 0);
    ef = {1'b1, q.pop_front(), 1'b0};
    checks++; if (bits[9:0] !== ef) begin errors++; $display("FAIL rst_next_frame got %b exp %b", bits[9:0], ef); end
    checks++; if (done_at != FL) begin errors++; $display("FAIL rst_next_done_at got %0d exp %0d", done_at, FL); end
  endtask

  task automatic test_tx_en;
    logic [9:0] ef;
    int bad;
    bad = 0;
    @(negedge clk); data_in = 8'h3C; tx_start = 1'b1; q.push_back(8'h3C);
    capture(FL + 10, UART_FRAME_BITS, 50);
    ef = {1'b1, q.pop_front(), 1'b0};
    checks++; if (bits[9:0] !== ef) begin errors++; $display("FAIL en_off_frame got %b exp %b", bits[9:0], ef); end
    checks++; if (done_cnt != 1 || done_at != FL)
      begin errors++; $display("FAIL en_off_done got cnt %0d at %0d exp 1 at %0d", done_cnt, done_at, FL); end
    @(negedge clk); tx_start = 1'b1; data_in = 8'hFF;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL en_off_idle got %0d active cycles exp 0", bad); end
    tx_start = 1'b0; tx_en = 1'b1;
  endtask

  task automatic test_parity;
    logic [7:0] pats [2] = '{8'h07, 8'h03};
    logic [8:0] e;
    logic [7:0] got;
    int pd, od;
    for (int i = 0; i < 2; i++) begin
      pd = 0; od = 0;
      @(negedge clk); p_data = pats[i]; p_start = 1'b1; pq.push_back({^pats[i], pats[i]});
      for (int k = 1; k <= 190; k++) begin
        @(negedge clk);
        p_start = 1'b0;
        p_line[k] = p_tx; o_line[k] = o_tx;
        if (p_done && pd == 0) pd = k;
        if (o_done && od == 0) od = k;
      end
      for (int b = 0; b < 8; b++) got[b] = p_line[(b + 1) * D + 8];
      e = pq.pop_front();
      checks++; if (got !== e[7:0]) begin errors++; $display("FAIL par_data got %h exp %h", got, e[7:0]); end
      checks++; if (p_line[9 * D + 8] !== e[8]) begin errors++; $display("FAIL par_even got %b exp %b", p_line[9 * D + 8], e[8]); end
      checks++; if (o_line[9 * D + 8] !== ~e[8]) begin errors++; $display("FAIL par_odd got %b exp %b", o_line[9 * D + 8], ~e[8]); end
      checks++; if (p_line[10 * D + 8] !== 1'b1) begin errors++; $display("FAIL par_stop got %b exp 1", p_line[10 * D + 8]); end
      checks++; if (pd != UART_FRAME_BITS_PAR * D || od != UART_FRAME_BITS_PAR * D)
        begin errors++; $display("FAIL par_len got %0d,%0d exp %0d", pd, od, UART_FRAME_BITS_PAR * D); end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    test_reset;
    test_frame;
    test_back_to_back;
    test_reset_mid;
    test_tx_en;
    test_parity;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8N1 UART transmitter. It serialises one byte per request onto the `tx` line, LSB first, with one start bit (0) and one stop bit (1).
- It is the transmit-side counterpart to `Top_module_RX` and uses the same `div`/`width` baud convention, so at equal `div` a TX→RX loopback is bit-exact.
- It sits between the APB register block (data/start/status) and the serial pin.

Parameters:
- `width`, 16: bit width of the baud divider counter.
- `div`, 16'd10417: clocks per serial bit. Legal range is 2..2^width-1. The default gives 9600 baud at 100 MHz.
- `PARITY_EN`, 0: 1 inserts a parity bit between data bit 7 and the stop bit (frame becomes 11 bits).
- `PARITY_ODD`, 0: with `PARITY_EN`=1, 0 selects even parity and 1 selects odd.

Ports:
- `clk`  input  1  system clock, rising edge.
- `arst`  input  1  reset, asynchronous, active-high.
- `tx_en`  input  1  transmitter enable; gates acceptance of new frames only.
- `tx_start`  input  1  request to send `data_in`; level-sampled each cycle.
- `data_in`  input  8  byte to send; captured on acceptance.
- `tx`  output  1  serial line; idle high.
- `busy`  output  1  frame in progress.
- `done`  output  1  one-cycle pulse at frame completion.

Behaviour:
- Reset (`arst`=1, asynchronous): `tx`=1, `busy`=0, `done`=0, state=IDLE, baud counter=0, bit index=0, shift register=0.
- FSM states are IDLE, START, DATA, PARITY (only present when `PARITY_EN`=1), STOP.
- Acceptance:
  - A frame is accepted in any cycle with state=IDLE, `tx_en`=1 and `tx_start`=1.
  - `data_in` is latched into the shift register, the baud counter is cleared, and the state moves to START.
  - `busy`=1 from the next cycle.
- Frame timing: if acceptance is at edge T, the line is driven as follows.
  - `tx`=0 (start bit) for cycles T+1 .. T+div.
  - Data bit i is driven for cycles T+1+(i+1)·div .. T+(i+2)·div, for i = 0..7, LSB first.
  - The parity bit, if enabled, is driven for the next div cycles.
  - The stop bit (`tx`=1) is driven for div cycles.
- Baud counter:
  - Counts 0..div-1; a bit tick is produced when the count equals div-1, and the counter then wraps to 0.
  - The counter is held at 0 in IDLE, so every bit lasts exactly div clocks, including the first.
- Parity: XOR of the 8 latched data bits, inverted when `PARITY_ODD`=1. It is computed from the latched copy, never from live `data_in`.
- Completion:
  - On the tick that ends the stop bit, the state returns to IDLE.
  - In that same cycle `done`=1 for exactly one clock, `busy`=0 and `tx`=1.
  - Total frame length is 10·div clocks (11·div with parity).
- Back-to-back: `tx_start`=1 during the `done` cycle (state is IDLE) is accepted. The next start bit begins on the following cycle, so the stop bit is exactly div long and there is no extra idle gap.
- `tx_start` while `busy`=1 is ignored. It is not queued, and `done` is unaffected.
- `data_in` changes after acceptance have no effect on the frame in flight.
- `tx_en` deasserted mid-frame: the current frame completes normally, including `done`. No new frame is accepted until `tx_en`=1.
- `tx_en`=0 in IDLE: `tx` stays 1 and `busy` stays 0.
- `arst` mid-frame: `tx` returns to 1 immediately (asynchronously). The frame is aborted, no `done` is produced, and the block is ready for `tx_start` on the first edge after `arst` deasserts.
- All outputs are registered, so `tx` is glitch-free.

Decomposition:
- Shared package `uart_pkg` holds:
  - state encoding localparams (IDLE/START/DATA/PARITY/STOP);
  - `UART_DATA_BITS`=8;
  - default `div` and `width`;
  - frame-length constants.
- `Top_module_RX` imports the same package.
- One sub-module, `uart_baud_gen`, is parameterised by `div`/`width`. Its inputs are `clk`, `arst` and a synchronous clear; its output is a one-cycle `tick`. It is reusable by RX.
- The FSM, shift register and parity logic live in `uart_tx`.

Test Plan:
1. `div`=16: accept 8'hA5 → `tx` sequence 0,1,0,1,0,0,1,0,1,1, each bit exactly 16 clocks; `done` one cycle at T+160; `busy` high for cycles T+1..T+159.
2. Default `div`: `uart_tx` looped into `Top_module_RX` sends 8'h3C, 8'h00, 8'hFF → RX `data_out` matches each byte with `error`=0.
3. `div`=16: hold `tx_start`=1 continuously with 8'h55 then 8'hAA → two frames with no gap (stop bit exactly 16 clocks); exactly two `done` pulses 160 clocks apart; `tx_start` pulses during `busy` produce no third frame.
4. `div`=16: assert `arst` at T+60 for 20 clocks during 8'hC3 → `tx`=1 within the same cycle, `busy`=0, no `done`; the next frame with 8'h96 is transmitted correctly.
5. `div`=16: deassert `tx_en` at T+50 → current frame completes with `done`; `tx_start` while `tx_en`=0 leaves `tx`=1 and `busy`=0.
6. `PARITY_EN`=1: 8'h07 gives parity bit 1 (even) or 0 (`PARITY_ODD`=1); frame is 176 clocks at `div`=16.
